// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Generates program-counter addresses, requests
// instruction words from instruction memory and holds each fetched word for
// the downstream enable-gated instruction register (ins -> d,
// ins_valid -> enable). Later stages can steer the PC through the redirect
// port for branches and jumps.
//
// Handshakes:
//   Memory side:  mem_req is a request/valid that stays asserted, with a
//                 stable mem_addr, until an edge samples mem_ready=1. On that
//                 edge mem_rdata is captured. mem_ready is ignored while
//                 mem_req=0.
//   Downstream:   ins_valid is the valid and ins_accept is the ready. A word
//                 transfers on an edge where both are 1. ins, pc_out and
//                 ins_valid are held stable until that edge. ins_accept is
//                 ignored while ins_valid=0.
//   Redirect:     overrides both handshakes on the edge where it is sampled.
//
// Ports:
//   clk          clock, rising-edge active
//   rst          asynchronous, active-high reset
//   mem_req      fetch request to instruction memory
//   mem_addr     fetch address (the current pc)
//   mem_ready    memory has mem_rdata valid for the current request
//   mem_rdata    instruction word from memory
//   ins          held instruction for downstream
//   pc_out       address of ins
//   pc_plus4     pc_out + 4 (modulo 2^WIDTH)
//   ins_valid    ins/pc_out hold a valid fetched instruction
//   ins_accept   downstream consumes ins this cycle
//   redirect     load redirect_pc and discard any held instruction
//   redirect_pc  redirect target (low two bits are forced to zero)
//   dbg_state    current FSM state (0 = FETCH, 1 = HOLD), for observation
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0080
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      ins,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             ins_valid,
    input  logic             ins_accept,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [0:0]       dbg_state
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    // The reset PC is word-aligned by construction; the mask keeps pc[1:0]
    // zero even if an unaligned value is supplied.
    localparam logic [WIDTH-1:0] RESET_PC_ALIGNED = {RESET_PC[WIDTH-1:2], 2'b00};
    localparam logic [WIDTH-1:0] FOUR             = WIDTH'(4);

    logic [0:0]       state;
    logic [WIDTH-1:0] pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= RESET_PC_ALIGNED;
            ins    <= 32'h0;
            pc_out <= RESET_PC_ALIGNED;
        end else if (redirect) begin
            // Redirect wins over a same-edge capture or accept; ins/pc_out
            // keep their old contents, only the valid flag is dropped.
            state <= FETCH;
            pc    <= {redirect_pc[WIDTH-1:2], 2'b00};
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ins    <= mem_rdata;
                        pc_out <= pc;
                        pc     <= pc + FOUR;
                        state  <= HOLD;
                    end
                end
                HOLD: begin
                    if (ins_accept) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // A valid instruction is held exactly while the FSM sits in HOLD, so the
    // valid flag is decoded from state rather than stored separately.
    assign ins_valid = (state == HOLD);
    assign mem_req   = (state == FETCH);
    assign mem_addr  = pc;
    assign pc_plus4  = pc_out + FOUR;
    assign dbg_state = state;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed self-checking bench for fetch_stage. Inputs change 1 ns after the
// rising edge and outputs are checked at that point, away from the edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ins;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        ins_valid;
    logic        ins_accept;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [0:0]  dbg_state;

    always #5 clk = ~clk;

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0080)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .ins         (ins),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .ins_valid   (ins_valid),
        .ins_accept  (ins_accept),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fetch one word at exp_pc: 'waits' cycles of mem_ready=0, capture, then
    // 'holds' cycles with ins_accept=0 before accepting.
    task automatic fetch_word(input logic [31:0] data, input int waits, input int holds);
        logic [31:0] exp_ins;
        exp_q.push_back(data);
        mem_rdata  = data;
        mem_ready  = 1'b0;
        ins_accept = 1'b0;
        for (int i = 0; i < waits; i++) begin
            step();
            check("wait_req", {31'b0, mem_req}, 32'd1);
            check("wait_addr", mem_addr, exp_pc);
            check("wait_valid", {31'b0, ins_valid}, 32'd0);
        end
        check("req", {31'b0, mem_req}, 32'd1);
        check("req_addr", mem_addr, exp_pc);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'h5A5A_5A5A;   // must not leak into the held word
        exp_ins = exp_q.pop_front();
        check("cap_valid", {31'b0, ins_valid}, 32'd1);
        check("cap_req", {31'b0, mem_req}, 32'd0);
        check("cap_state", {31'b0, dbg_state}, {31'b0, ST_HOLD});
        check("cap_ins", ins, exp_ins);
        check("cap_pc_out", pc_out, exp_pc);
        check("cap_pc_plus4", pc_plus4, exp_pc + 32'd4);
        for (int i = 0; i < holds; i++) begin
            mem_ready = 1'b1;        // ignored outside FETCH
            step();
            check("hold_valid", {31'b0, ins_valid}, 32'd1);
            check("hold_req", {31'b0, mem_req}, 32'd0);
            check("hold_ins", ins, exp_ins);
            check("hold_pc_out", pc_out, exp_pc);
        end
        mem_ready  = 1'b0;
        ins_accept = 1'b1;
        step();
        ins_accept = 1'b0;
        exp_pc = exp_pc + 32'd4;
        check("acc_valid", {31'b0, ins_valid}, 32'd0);
        check("acc_req", {31'b0, mem_req}, 32'd1);
        check("acc_addr", mem_addr, exp_pc);
        check("acc_ins_kept", ins, exp_ins);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] last_ins;
        logic [31:0] last_pc;
        rst         = 1'b1;
        mem_ready   = 1'b0;
        mem_rdata   = 32'h0;
        ins_accept  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        exp_pc      = 32'h0000_0080;

        // Reset values
        #3;
        check("rst_req", {31'b0, mem_req}, 32'd1);
        check("rst_addr", mem_addr, 32'h0000_0080);
        check("rst_valid", {31'b0, ins_valid}, 32'd0);
        check("rst_ins", ins, 32'h0);
        check("rst_pc_out", pc_out, 32'h0000_0080);
        check("rst_pc_plus4", pc_plus4, 32'h0000_0084);
        check("rst_state", {31'b0, dbg_state}, {31'b0, ST_FETCH});
        step();
        step();
        rst = 1'b0;

        // Zero-wait fetches at 0x80 and 0x84
        fetch_word(32'hAAAA_0001, 0, 0);
        fetch_word(32'hAAAA_0002, 0, 0);
        check("seq_pc_plus4", pc_plus4, 32'h0000_0088);

        // Memory stalls for 3 cycles
        fetch_word(32'hBBBB_0003, 3, 0);
        // Downstream stalls for 5 cycles
        fetch_word(32'hCCCC_0004, 0, 5);
        // Mixed stalls with randomly drawn lengths
        fetch_word(32'hDDDD_0005, $urandom_range(0, 2), $urandom_range(0, 3));
        check("seq_addr", mem_addr, 32'h0000_0094);

        // Redirect on the same edge as mem_ready: capture is discarded
        last_ins    = ins;
        last_pc     = pc_out;
        mem_rdata   = 32'hDEAD_BEEF;
        mem_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        mem_ready = 1'b0;
        redirect  = 1'b0;
        exp_pc    = 32'h0000_0200;
        check("redir_valid", {31'b0, ins_valid}, 32'd0);
        check("redir_req", {31'b0, mem_req}, 32'd1);
        check("redir_addr", mem_addr, 32'h0000_0200);
        check("redir_ins_kept", ins, last_ins);
        check("redir_pc_kept", pc_out, last_pc);
        fetch_word(32'hEEEE_0006, 0, 1);

        // Redirect while holding, with a simultaneous accept
        exp_q.push_back(32'h1234_5678);
        mem_rdata = 32'h1234_5678;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("hr_ins", ins, exp_q.pop_front());
        check("hr_valid", {31'b0, ins_valid}, 32'd1);
        redirect    = 1'b1;
        ins_accept  = 1'b1;
        redirect_pc = 32'h1000_0010;
        step();
        redirect   = 1'b0;
        ins_accept = 1'b0;
        exp_pc     = 32'h1000_0010;
        check("hr_valid_drop", {31'b0, ins_valid}, 32'd0);
        check("hr_addr", mem_addr, 32'h1000_0010);
        check("hr_ins_kept", ins, 32'h1234_5678);
        check("hr_pc_kept", pc_out, 32'h0000_0204);

        // Redirect to the top word, then wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        exp_pc   = 32'hFFFF_FFFC;
        check("top_addr", mem_addr, 32'hFFFF_FFFC);
        fetch_word(32'hF0F0_0007, 0, 0);
        check("wrap_pc_out", pc_out, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
        check("wrap_addr", mem_addr, 32'h0000_0000);

        // Asynchronous reset mid-cycle while holding
        mem_rdata = 32'h7777_0008;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("pre_rst_valid", {31'b0, ins_valid}, 32'd1);
        check("pre_rst_ins", ins, 32'h7777_0008);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", {31'b0, ins_valid}, 32'd0);
        check("arst_ins", ins, 32'h0);
        check("arst_addr", mem_addr, 32'h0000_0080);
        check("arst_req", {31'b0, mem_req}, 32'd1);
        check("arst_pc_plus4", pc_plus4, 32'h0000_0084);
        #1;
        rst = 1'b0;
        exp_pc = 32'h0000_0080;
        fetch_word(32'h9999_0009, 0, 0);

        check("q_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time bound so the run always terminates
    initial begin
        #20000;
        $display("FAIL timeout: got=running exp=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that generates program-counter addresses, requests instructions from instruction memory with a ready handshake, and holds each fetched word for the downstream instruction register (the enable-gated 32-bit `register` stage). It is the producer directly upstream of that register: `ins` drives the register's `d`, and `ins_valid` qualifies its `enable`. A redirect port lets later stages steer the PC for branches and jumps.

## Interface
Parameters:
- `WIDTH`, 32, address/PC width in bits
- `RESET_PC`, 32'h0000_0080, PC loaded on reset (word-aligned)

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `mem_req`  output  1  fetch request to instruction memory
- `mem_addr`  output  WIDTH  fetch address
- `mem_ready`  input  1  memory has `mem_rdata` valid for the current request
- `mem_rdata`  input  32  instruction word from memory
- `ins`  output  32  held instruction for downstream
- `pc_out`  output  WIDTH  address of `ins`
- `pc_plus4`  output  WIDTH  `pc_out + 4`
- `ins_valid`  output  1  `ins`/`pc_out` hold a valid fetched instruction
- `ins_accept`  input  1  downstream consumes `ins` this cycle
- `redirect`  input  1  load new PC and discard any held instruction
- `redirect_pc`  input  WIDTH  redirect target

## Operation
- Internal state: `pc` (next fetch address) and a 2-state FSM: FETCH, HOLD.
- Reset (asserted any time, takes effect immediately): `pc`=RESET_PC, state=FETCH, `ins`=0, `pc_out`=RESET_PC, `ins_valid`=0. Outputs therefore read `mem_req`=1, `mem_addr`=RESET_PC, `pc_plus4`=RESET_PC+4.
- `mem_req` = (state==FETCH), combinational from state; `mem_addr` = `pc` combinationally.
- FETCH: on an edge with `mem_ready`=1: `ins`<=`mem_rdata`, `pc_out`<=`pc`, `pc`<=`pc`+4, `ins_valid`<=1, state<=HOLD. With `mem_ready`=0: no change, request stays asserted with a stable address.
- HOLD: `mem_req`=0; `ins`, `pc_out`, and `ins_valid`=1 are held stable. On an edge with `ins_accept`=1: `ins_valid`<=0, state<=FETCH. `ins` and `pc_out` keep their last values.
- `ins_accept` is ignored when `ins_valid`=0. `mem_ready` is ignored outside FETCH.
- Redirect has top priority. On an edge with `redirect`=1, in any state: `pc`<={`redirect_pc`[WIDTH-1:2],2'b00}, `ins_valid`<=0, state<=FETCH. A simultaneous `mem_ready` capture or `ins_accept` is discarded, and `ins`/`pc_out` are unchanged.
- Arithmetic: `pc`+4 and `pc_plus4` are computed modulo 2^WIDTH, so an address of 2^WIDTH-4 wraps to 0. The low two bits of `pc` are always 0.

## Timing
- Zero-wait memory (`mem_ready`=1 on the first request cycle): `ins_valid` rises 1 cycle after `mem_req` is sampled.
- Each additional low-`mem_ready` cycle adds 1 cycle of latency.
- Maximum throughput is 1 instruction per 2 cycles: FETCH, then HOLD accepted.
- `ins_valid` falls on the edge that samples `ins_accept`. `mem_req` rises in the same cycle.
- Asserting reset mid-request abandons the transaction. The first post-reset request is to RESET_PC.
- `pc_plus4` changes only when `pc_out` changes.

## Test plan
- Reset then zero-wait memory returning 0xAAAA0001, 0xAAAA0002 with `ins_accept`=1: `mem_addr` reads 0x80, then 0x84. `ins`/`pc_out` read 0xAAAA0001/0x80, then 0xAAAA0002/0x84. `pc_plus4` reads 0x84, then 0x88.
- `mem_ready` held low 3 cycles: `mem_req`=1 and `mem_addr`=0x80 stay stable. `ins_valid` rises exactly 1 cycle after the first sampled `mem_ready`=1.
- Instruction fetched with `ins_accept`=0 for 5 cycles: `ins_valid`=1, `mem_req`=0, `ins` unchanged throughout. On accept, the next fetch is at 0x84.
- `redirect`=1 with `redirect_pc`=0x0000_0203 in the same edge as `mem_ready`=1: the capture is discarded, `ins_valid`=0, and the next `mem_addr`=0x200.
- Redirect to 0xFFFF_FFFC, then fetch: `pc_out`=0xFFFF_FFFC, `pc_plus4`=0, and the next `mem_addr`=0.
- `rst` pulsed asynchronously (mid-cycle) while in HOLD with `ins_valid`=1: `ins_valid`=0 and `ins`=0 immediately. `mem_addr`=0x80 and `mem_req`=1 take effect before the next edge.
